// File: rtl/cr_osf_stat_counter_bank.sv
// cr_osf_stat_counter_bank: a bank of N_CHANNELS wide event counters. Each channel
// has its own count-by amount and a sticky overflow flag. Writing the GLBL register
// takes an atomic snapshot of every channel, and the snapshot can optionally clear
// the live counters. Registers are read from the shadow copies through the local
// register interface.
// Optional feature macro: CR_OSF_STAT_SAT_EN. When it is defined, counters saturate
// at all-ones. When it is undefined, counters wrap modulo 2^N_COUNTER_BITS.
module cr_osf_stat_counter_bank #(
  parameter int unsigned N_CHANNELS      = 4,
  parameter int unsigned N_COUNTER_BITS  = 50,
  parameter int unsigned N_COUNT_BY_BITS = 4,
  parameter int unsigned N_ADDR_BITS     = 10,
  parameter int unsigned BASE_ADDRESS    = 0,
  parameter int unsigned GLBL_ADDRESS    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_ADDR_BITS-1:0]                reg_addr,
  input  logic                                  rd_stb,
  input  logic                                  wr_stb,
  input  logic [31:0]                           reg_data,
  input  logic [N_CHANNELS-1:0]                 count_stb,
  input  logic [N_CHANNELS*N_COUNT_BY_BITS-1:0] count_by,
  output logic [31:0]                           rd_data,
  output logic                                  rd_ack,
  output logic                                  snap_done,
  output logic [N_CHANNELS-1:0]                 ovf
);

  localparam int unsigned SUM_W =
    ((N_COUNTER_BITS > N_COUNT_BY_BITS) ? N_COUNTER_BITS : N_COUNT_BY_BITS) + 1;

  logic [N_COUNTER_BITS-1:0] live_q   [N_CHANNELS];
  logic [N_COUNTER_BITS-1:0] live_d   [N_CHANNELS];
  logic [N_COUNTER_BITS-1:0] shadow_q [N_CHANNELS];
  logic [N_COUNTER_BITS-1:0] shadow_d [N_CHANNELS];
  logic [N_CHANNELS-1:0]     ovf_q, ovf_d;
  logic                      clr_on_snap_q, clr_on_snap_d;
  logic [31:0]               rd_data_q, rd_data_d;
  logic                      rd_ack_q, rd_ack_d;
  logic                      snap_done_q, snap_done_d;

  logic glbl_wr;
  logic snap_req;
  logic unused_reg_data;

  assign glbl_wr         = wr_stb && (reg_addr == N_ADDR_BITS'(GLBL_ADDRESS));
  assign snap_req        = glbl_wr && reg_data[0];
  assign unused_reg_data = ^reg_data[31:2];

  // Per-channel next state: clear/snapshot/increment with overflow tracking
  always_comb begin
    logic [SUM_W-1:0]           sum;
    logic [N_COUNT_BY_BITS-1:0] by_c;
    logic                       carry;
    logic                       chan_wr;
    sum   = '0;
    by_c  = '0;
    carry = 1'b0;
    chan_wr = 1'b0;
    ovf_d = ovf_q;
    for (int unsigned c = 0; c < N_CHANNELS; c++) begin
      live_d[c]   = live_q[c];
      shadow_d[c] = snap_req ? live_q[c] : shadow_q[c];
      by_c    = count_by[c*N_COUNT_BY_BITS +: N_COUNT_BY_BITS];
      sum     = SUM_W'(live_q[c]) + SUM_W'(by_c);
      carry   = |sum[SUM_W-1:N_COUNTER_BITS];
      chan_wr = wr_stb && ((reg_addr == N_ADDR_BITS'(BASE_ADDRESS + 2*c)) ||
                           (reg_addr == N_ADDR_BITS'(BASE_ADDRESS + 2*c + 1)));
      if (chan_wr || (snap_req && clr_on_snap_q)) begin
        // The increment that arrives in the clear cycle is kept, not lost.
        live_d[c] = count_stb[c] ? N_COUNTER_BITS'(by_c) : '0;
        ovf_d[c]  = 1'b0;
      end else if (count_stb[c]) begin
`ifdef CR_OSF_STAT_SAT_EN
        live_d[c] = carry ? '1 : sum[N_COUNTER_BITS-1:0];
        if (carry || (sum[N_COUNTER_BITS-1:0] == '1)) ovf_d[c] = 1'b1;
`else
        live_d[c] = sum[N_COUNTER_BITS-1:0];
        if (carry) ovf_d[c] = 1'b1;
`endif
      end
    end
  end

  // Control register, snapshot pulse and registered read mux
  always_comb begin
    logic        hit;
    logic [31:0] val;
    hit = 1'b0;
    val = '0;
    clr_on_snap_d = glbl_wr ? reg_data[1] : clr_on_snap_q;
    snap_done_d   = snap_req;
    if (reg_addr == N_ADDR_BITS'(GLBL_ADDRESS)) begin
      hit = 1'b1;
      val = {30'(ovf_q), clr_on_snap_q, 1'b0};
    end
    for (int unsigned c = 0; c < N_CHANNELS; c++) begin
      if (reg_addr == N_ADDR_BITS'(BASE_ADDRESS + 2*c)) begin
        hit = 1'b1;
        val = shadow_q[c][31:0];
      end else if (reg_addr == N_ADDR_BITS'(BASE_ADDRESS + 2*c + 1)) begin
        hit = 1'b1;
        val = 32'(shadow_q[c][N_COUNTER_BITS-1:32]);
      end
    end
    // A write in the same cycle wins, so a colliding read is dropped.
    rd_ack_d  = rd_stb && !wr_stb && hit;
    rd_data_d = rd_ack_d ? val : '0;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CHANNELS; c++) begin
        live_q[c]   <= '0;
        shadow_q[c] <= '0;
      end
      ovf_q         <= '0;
      clr_on_snap_q <= 1'b0;
      rd_data_q     <= '0;
      rd_ack_q      <= 1'b0;
      snap_done_q   <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_CHANNELS; c++) begin
        live_q[c]   <= live_d[c];
        shadow_q[c] <= shadow_d[c];
      end
      ovf_q         <= ovf_d;
      clr_on_snap_q <= clr_on_snap_d;
      rd_data_q     <= rd_data_d;
      rd_ack_q      <= rd_ack_d;
      snap_done_q   <= snap_done_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_ack    = rd_ack_q;
  assign snap_done = snap_done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cr_osf_stat_counter_bank.sv
// Testbench for cr_osf_stat_counter_bank. It runs directed scenarios and randomized
// traffic. Every cycle is checked against a behavioural model of the counter bank.
module tb_cr_osf_stat_counter_bank;

  localparam int N  = 4;
  localparam int NB = 50;
  localparam int CB = 48;
  localparam int AW = 10;
  localparam logic [9:0]  GLBL = 10'd8;
  localparam logic [63:0] MAXV = (64'd1 << NB) - 64'd1;
  localparam logic [63:0] BIGB = (64'd1 << CB) - 64'd1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   reg_addr = '0;
  logic            rd_stb = 1'b0;
  logic            wr_stb = 1'b0;
  logic [31:0]     reg_data = '0;
  logic [N-1:0]    count_stb = '0;
  logic [N*CB-1:0] count_by = '0;
  logic [31:0]     rd_data;
  logic            rd_ack;
  logic            snap_done;
  logic [N-1:0]    ovf;

  cr_osf_stat_counter_bank #(
    .N_CHANNELS(N), .N_COUNTER_BITS(NB), .N_COUNT_BY_BITS(CB),
    .N_ADDR_BITS(AW), .BASE_ADDRESS(0), .GLBL_ADDRESS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .rd_stb(rd_stb), .wr_stb(wr_stb),
    .reg_data(reg_data), .count_stb(count_stb), .count_by(count_by),
    .rd_data(rd_data), .rd_ack(rd_ack), .snap_done(snap_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_live   [N];
  logic [63:0] m_shadow [N];
  bit          m_ovf    [N];
  bit          m_clr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_ovf();
    logic [3:0] v;
    for (int c = 0; c < N; c++) v[c] = m_ovf[c];
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_live[c] = '0; m_shadow[c] = '0; m_ovf[c] = 0;
    end
    m_clr = 0;
  endtask

  // One bus cycle: drive at negedge, advance model, check 1ns after the posedge
  task automatic step(input bit wr, input bit rd, input logic [9:0] addr,
                      input logic [31:0] data, input logic [N-1:0] stb,
                      input logic [N*CB-1:0] byv);
    bit          exp_ack, snap;
    logic [63:0] exp_rd;
    logic [63:0] b, s;
    int          ch;
    @(negedge clk);
    wr_stb = wr; rd_stb = rd; reg_addr = addr; reg_data = data;
    count_stb = stb; count_by = byv;
    exp_rd = 0;
    exp_ack = 0;
    if (rd && !wr) begin
      if (addr == GLBL) begin
        exp_ack = 1;
        exp_rd = {32'd0, 26'd0, model_ovf(), m_clr, 1'b0};
      end else if (addr < 10'(2*N)) begin
        exp_ack = 1;
        ch = int'(addr) / 2;
        exp_rd = (addr % 2 == 0) ? (m_shadow[ch] % 64'h1_0000_0000)
                                 : (m_shadow[ch] / 64'h1_0000_0000);
      end
    end
    snap = wr && (addr == GLBL) && data[0];
    for (int c = 0; c < N; c++) begin
      b = 64'(byv[c*CB +: CB]);
      if (snap) m_shadow[c] = m_live[c];
      if ((wr && (int'(addr) / 2 == c) && addr < 10'(2*N)) || (snap && m_clr)) begin
        m_live[c] = stb[c] ? b : 64'd0;
        m_ovf[c]  = 0;
      end else if (stb[c]) begin
        s = m_live[c] + b;
`ifdef CR_OSF_STAT_SAT_EN
        if (s >= MAXV) begin m_live[c] = MAXV; m_ovf[c] = 1; end
        else m_live[c] = s;
`else
        if (s > MAXV) begin m_live[c] = s - (MAXV + 64'd1); m_ovf[c] = 1; end
        else m_live[c] = s;
`endif
      end
    end
    if (wr && addr == GLBL) m_clr = data[1];
    @(posedge clk);
    #1;
    chk("rd_ack", 64'(rd_ack), 64'(exp_ack));
    chk("rd_data", 64'(rd_data), exp_rd);
    chk("snap_done", 64'(snap_done), 64'(snap));
    chk("ovf", 64'(ovf), 64'(model_ovf()));
  endtask

  task automatic idle();                 step(0, 0, 10'd0, 32'd0, '0, '0); endtask
  task automatic rd(input logic [9:0] a); step(0, 1, a, 32'd0, '0, '0); endtask
  task automatic wr(input logic [9:0] a, input logic [31:0] d); step(1, 0, a, d, '0, '0); endtask

  function automatic logic [N*CB-1:0] by_one(input int c, input logic [63:0] v);
    logic [N*CB-1:0] r;
    r = '0;
    r[c*CB +: CB] = v[CB-1:0];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_stb = 0; rd_stb = 0; count_stb = '1; count_by = '1;
    repeat (3) @(negedge clk);
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_snap_done", 64'(snap_done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    model_clear();
    count_stb = '0; count_by = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N*CB-1:0] byv;
    logic [N-1:0]    stb;
    int              op;
    model_clear();

    // Reset with strobes active; snapshot and read every part back as zero
    do_reset();
    wr(GLBL, 32'h1);
    for (int a = 0; a < 2*N; a++) begin
      rd(10'(a));
      chk("t1_zero", 64'(rd_data), 64'd0);
    end
    rd(GLBL);
    chk("t1_glbl", 64'(rd_data), 64'd0);

    // Channel 1 counts by 5 for 10 cycles, then snapshot and read
    repeat (10) step(0, 0, 10'd0, 32'd0, 4'b0010, by_one(1, 64'd5));
    step(1, 0, GLBL, 32'h1, 4'b0010, by_one(1, 64'd5));
    chk("t2_snap_done", 64'(snap_done), 64'd1);
    rd(10'd2);
    chk("t2_ack", 64'(rd_ack), 64'd1);
    chk("t2_part0", 64'(rd_data), 64'd50);
    chk("t2_snap_once", 64'(snap_done), 64'd0);
    wr(GLBL, 32'h1);
    rd(10'd2);
    chk("t2_live_cont", 64'(rd_data), 64'd55);

    // Clear-on-snapshot keeps the increment from the snapshot cycle
    wr(10'd0, 32'h0);
    wr(GLBL, 32'h2);
    repeat (4) step(0, 0, 10'd0, 32'd0, 4'b0001, by_one(0, 64'd3));
    step(1, 0, GLBL, 32'h3, 4'b0001, by_one(0, 64'd7));
    rd(10'd0);
    chk("t3_shadow", 64'(rd_data), 64'd12);
    wr(GLBL, 32'h3);
    rd(10'd0);
    chk("t3_live", 64'(rd_data), 64'd7);

    // Drive channel 3 to 2^50-2, then add 4
    wr(10'd6, 32'h0);
    repeat (4) step(0, 0, 10'd0, 32'd0, 4'b1000, by_one(3, BIGB));
    step(0, 0, 10'd0, 32'd0, 4'b1000, by_one(3, 64'd2));
    chk("t4_no_ovf_yet", 64'(ovf[3]), 64'd0);
    step(0, 0, 10'd0, 32'd0, 4'b1000, by_one(3, 64'd4));
    chk("t4_ovf", 64'(ovf[3]), 64'd1);
    wr(GLBL, 32'h1);
    rd(10'd6);
`ifdef CR_OSF_STAT_SAT_EN
    chk("t4_part0", 64'(rd_data), 64'hFFFF_FFFF);
    rd(10'd7);
    chk("t4_part1", 64'(rd_data), 64'h3_FFFF);
`else
    chk("t4_part0", 64'(rd_data), 64'd2);
    rd(10'd7);
    chk("t4_part1", 64'(rd_data), 64'd0);
`endif

    // Channel clear while an increment arrives; overflow flag cleared
    repeat (5) step(0, 0, 10'd0, 32'd0, 4'b0100, by_one(2, BIGB));
    chk("t5_ovf_set", 64'(ovf[2]), 64'd1);
    step(1, 0, 10'd5, 32'hDEAD_BEEF, 4'b0101, by_one(2, 64'd9) | by_one(0, 64'd1));
    wr(GLBL, 32'h1);
    chk("t5_ovf_clr", 64'(ovf[2]), 64'd0);
    rd(10'd4);
    chk("t5_ch2", 64'(rd_data), 64'd9);

    // All channels strobed every cycle with distinct amounts
    do_reset();
    byv = '0;
    for (int c = 0; c < N; c++) byv[c*CB +: CB] = CB'(3*c + 2);
    repeat (100) step(0, 0, 10'd0, 32'd0, '1, byv);
    wr(GLBL, 32'h1);
    for (int c = 0; c < N; c++) begin
      rd(10'(2*c));
      chk("t6_multi", 64'(rd_data), 64'(100*(3*c + 2)));
    end

    // Simultaneous read/write: the write wins and the read is not acked
    step(1, 1, 10'd0, 32'd0, '0, '0);
    chk("t6_rdwr_noack", 64'(rd_ack), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      stb = N'($urandom);
      byv = '0;
      for (int c = 0; c < N; c++)
        byv[c*CB +: CB] = ($urandom_range(0, 19) == 0) ? CB'({$urandom, $urandom})
                                                       : CB'($urandom_range(0, 15));
      op = $urandom_range(0, 9);
      if (op == 0)      step(1, 0, GLBL, {30'd0, 2'($urandom)}, stb, byv);
      else if (op == 1) step(1, 0, 10'($urandom_range(0, 2*N-1)), $urandom, stb, byv);
      else if (op <= 4) step(0, 1, ($urandom_range(0, 9) == 0) ? 10'($urandom)
                                   : 10'($urandom_range(0, 10)), 32'd0, stb, byv);
      else              step(0, 0, 10'd0, 32'd0, stb, byv);
    end

    // Out-of-range reads
    rd(10'd9);
    chk("oor_9", 64'(rd_ack), 64'd0);
    rd(10'h3FF);
    chk("oor_3ff", 64'(rd_ack), 64'd0);
    chk("oor_data", 64'(rd_data), 64'd0);

    // Reset asserted while a read is in flight
    @(negedge clk);
    wr_stb = 0; count_stb = '0; rd_stb = 1; reg_addr = 10'd2;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 chk("mid_rst_ack", 64'(rd_ack), 64'd0);
    @(negedge clk);
    rd_stb = 0;
    @(posedge clk);
    #1 chk("mid_rst_ack2", 64'(rd_ack), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    idle();
    chk("post_rst_ovf", 64'(ovf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
